// File: rtl/adder_sub_pipe_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encoding and pipe depth.
package adder_sub_pipe_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // One pipeline stage resolves one slice of the carry chain.
  function automatic int stages_of(input int n, input int slice);
    return n / slice;
  endfunction

endpackage

// File: rtl/adder_sub_pipe_add_slice.sv
// One slice of the carry chain: W-bit add with carry in/out and the carry into the MSB.
module adder_sub_pipe_add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cm
);

  logic [W-1:0] low;

  // Split at the MSB so the carry into it is visible for signed overflow.
  assign low      = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
  assign cm       = low[W-1];
  assign s[W-2:0] = low[W-2:0];
  assign {co, s[W-1]} = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, cm};

endmodule

// File: rtl/adder_sub_pipe.sv
// Pipelined add/subtract unit: one SLICE-bit carry slice per stage, valid/ready on both
// sides, status flags and optional signed saturation formed in the last stage.
module adder_sub_pipe
  import adder_sub_pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         cnt,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int STAGES = stages_of(N, SLICE);
  localparam int LAST   = STAGES - 1;
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  if ((N % SLICE) != 0 || SLICE < 2) begin : g_bad_width
    $error("adder_sub_pipe: N must be a multiple of SLICE and SLICE must be at least 2");
  end

  // The whole pipe moves or holds as one; bubbles are kept in place.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             v_i;
    logic             cnt_i;
    logic             sat_i;
    logic             c_i;
    logic [N-1:0]     a_i;
    logic [N-1:0]     b_i;
    logic [N-1:0]     r_i;
    logic [N-1:0]     r_o;
    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sum;
    logic             co;
    logic             cm;

    if (gi == 0) begin : g_src
      assign v_i   = in_valid;
      assign a_i   = a;
      assign b_i   = b;
      assign cnt_i = cnt;
      assign sat_i = sat;
      assign c_i   = cin;
      assign r_i   = '0;
    end else begin : g_src
      assign v_i   = g_stage[gi-1].g_reg.v_q;
      assign a_i   = g_stage[gi-1].g_reg.a_q;
      assign b_i   = g_stage[gi-1].g_reg.b_q;
      assign cnt_i = g_stage[gi-1].g_reg.cnt_q;
      assign sat_i = g_stage[gi-1].g_reg.sat_q;
      assign c_i   = g_stage[gi-1].g_reg.c_q;
      assign r_i   = g_stage[gi-1].g_reg.r_q;
    end

    assign b_eff = (mode_e'(cnt_i) == MODE_SUB) ? ~b_i[gi*SLICE +: SLICE]
                                                 :  b_i[gi*SLICE +: SLICE];

    adder_sub_pipe_add_slice #(
      .W (SLICE)
    ) u_slice (
      .a  (a_i[gi*SLICE +: SLICE]),
      .b  (b_eff),
      .ci (c_i),
      .s  (sum),
      .co (co),
      .cm (cm)
    );

    always_comb begin
      r_o                    = r_i;
      r_o[gi*SLICE +: SLICE] = sum;
    end

    if (gi < LAST) begin : g_reg
      logic         v_q;
      logic         cnt_q;
      logic         sat_q;
      logic         c_q;
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;
      logic [N-1:0] r_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q   <= 1'b0;
          cnt_q <= 1'b0;
          sat_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          r_q   <= '0;
        end else if (adv) begin
          v_q   <= v_i;
          cnt_q <= cnt_i;
          sat_q <= sat_i;
          c_q   <= co;
          a_q   <= a_i;
          b_q   <= b_i;
          r_q   <= r_o;
        end
      end
    end
  end

  // With overflow both effective operands share A's sign, so A's MSB picks the clamp.
  logic         ovf_n;
  logic [N-1:0] s_n;

  assign ovf_n = g_stage[LAST].cm ^ g_stage[LAST].co;

  always_comb begin
    s_n = g_stage[LAST].r_o;
    if (ovf_n && g_stage[LAST].sat_i) begin
      s_n = g_stage[LAST].a_i[N-1] ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stage[LAST].v_i;
      s         <= s_n;
      cout      <= g_stage[LAST].co;
      ovf       <= ovf_n;
      zero      <= (s_n == '0);
      neg       <= s_n[N-1];
    end
  end

endmodule

// File: tb/tb_adder_sub_pipe.sv
// Self-checking bench for adder_sub_pipe: directed table at N=32/SLICE=8, backpressure and
// mid-stream reset sequences, plus randomized runs at N=8/SLICE=8 and N=12/SLICE=4.
`timescale 1ns/1ps
module tb_adder_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Reference: {cout, ovf, zero, neg, s[63:0]} for an n-bit unit.
  function automatic logic [67:0] model(input int n, input logic [63:0] ta, input logic [63:0] tb,
                                        input logic tcin, input logic tcnt, input logic tsat);
    logic [63:0] mask, be, r;
    logic [64:0] full;
    logic        co, ov;
    mask = (64'd1 << n) - 64'd1;
    be   = (tcnt ? ~tb : tb) & mask;
    full = {1'b0, ta & mask} + {1'b0, be} + 65'(tcin);
    r    = full[63:0] & mask;
    co   = full[n];
    ov   = (ta[n-1] == be[n-1]) && (r[n-1] != ta[n-1]);
    if (ov && tsat) r = ta[n-1] ? (64'd1 << (n - 1)) : (mask >> 1);
    return {co, ov, (r == 64'd0), r[n-1], r};
  endfunction

  function automatic logic [63:0] pick(input int n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (n - 1);
      3:       return mask >> 1;
      4:       return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // ---------------- main unit, N=32 SLICE=8 ----------------
  logic        rst, in_valid, in_ready, cin, cnt, sat, out_valid, out_ready;
  logic        cout, ovf, zero, neg;
  logic [31:0] a, b, s;

  adder_sub_pipe #(.N(32), .SLICE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .cnt(cnt), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  logic [67:0] sb[$];
  logic [67:0] exp_next;
  logic [67:0] e_main;
  logic        stall_prev = 1'b0;
  logic [35:0] held_prev;
  int          n_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev)
        chk("hold32", 68'({out_valid, cout, ovf, zero, neg, s}), 68'({1'b1, held_prev}));
      if (in_valid && in_ready) sb.push_back(exp_next);
      if (out_valid && out_ready) begin
        n_out++;
        chk("out32_pending", 68'(sb.size() != 0), 68'(1));
        if (sb.size() != 0) begin
          e_main = sb.pop_front();
          $display("out32 #%0d s=%h cout=%b ovf=%b zero=%b neg=%b", n_out, s, cout, ovf, zero, neg);
          chk("out32", {cout, ovf, zero, neg, 64'(s)}, e_main);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_prev  = {cout, ovf, zero, neg, s};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                      input logic tcnt, input logic tsat, input logic [67:0] texp);
    int acc;
    a = ta; b = tb; cin = tcin; cnt = tcnt; sat = tsat; exp_next = texp;
    in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready && rst) begin
        acc = 1;
        break;
      end
    end
    chk("accept32", 68'(acc), 68'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                        input logic tcnt, input logic tsat);
    send(ta, tb, tcin, tcnt, tsat, model(32, 64'(ta), 64'(tb), tcin, tcnt, tsat));
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain32", 68'(sb.size()), 68'(0));
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, cnt, sat;
    logic [31:0] es;
    logic        ec, eo, ez, en;
  } vec_t;

  vec_t tv[14];
  int   lat, n0;

  initial begin
    tv[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[11] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[13] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; cnt = 1'b0; sat = 1'b0; exp_next = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_outs", 68'({out_valid, in_ready, cout, ovf, zero, neg, s}),
        68'({1'b0, 1'b1, 4'b0000, 32'h0}));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single beat into an empty pipe: result appears STAGES cycles after acceptance.
    a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; cnt = 1'b0; sat = 1'b0;
    exp_next = model(32, 64'(a), 64'(b), cin, cnt, sat);
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency32", 68'(lat), 68'(4));
    drain();

    for (int i = 0; i < 14; i++)
      send(tv[i].a, tv[i].b, tv[i].cin, tv[i].cnt, tv[i].sat,
           {tv[i].ec, tv[i].eo, tv[i].ez, tv[i].en, 64'(tv[i].es)});
    drain();

    // Backpressure: 8 back-to-back beats with a 3-cycle output stall mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_m($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 68'(in_ready), 68'(0));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 68'(n_out - n0), 68'(8));

    // Reset with three beats in flight, none yet at the output.
    for (int i = 0; i < 3; i++) send_m(32'h100 + 32'(i), 32'h5, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_mid", 68'({out_valid, in_ready, s}), 68'({1'b0, 1'b1, 32'h0}));
    sb.delete();
    n0 = n_out;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send_m(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (6) @(posedge clk);
    #1;
    chk("rst_count", 68'(n_out - n0), 68'(1));

    for (int k = 0; k < 3000; k++) begin
      if (g_aux[0].x_done && g_aux[1].x_done) break;
      @(posedge clk);
    end
    chk("aux_done", 68'({g_aux[0].x_done, g_aux[1].x_done}), 68'(2'b11));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- randomized units at other widths ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_aux
    localparam int AN   = (gi == 0) ? 8 : 12;
    localparam int AS   = (gi == 0) ? 8 : 4;
    localparam int ALAT = AN / AS;

    logic          x_rst, x_in_valid, x_in_ready, x_cin, x_cnt, x_sat;
    logic          x_out_valid, x_out_ready, x_cout, x_ovf, x_zero, x_neg;
    logic [AN-1:0] x_a, x_b, x_s;
    logic [67:0]   x_sb[$];
    logic [67:0]   x_e;
    logic          x_done = 1'b0;
    int            x_n = 0;
    int            x_lat;

    adder_sub_pipe #(.N(AN), .SLICE(AS)) u_dut (
      .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .cin(x_cin), .cnt(x_cnt), .sat(x_sat),
      .out_valid(x_out_valid), .out_ready(x_out_ready),
      .s(x_s), .cout(x_cout), .ovf(x_ovf), .zero(x_zero), .neg(x_neg)
    );

    always @(negedge clk) begin
      if (x_rst) begin
        if (x_in_valid && x_in_ready)
          x_sb.push_back(model(AN, 64'(x_a), 64'(x_b), x_cin, x_cnt, x_sat));
        if (x_out_valid && x_out_ready) begin
          x_n++;
          chk($sformatf("out%0d_pending", AN), 68'(x_sb.size() != 0), 68'(1));
          if (x_sb.size() != 0) begin
            x_e = x_sb.pop_front();
            $display("out%0d #%0d s=%h cout=%b ovf=%b zero=%b neg=%b",
                     AN, x_n, x_s, x_cout, x_ovf, x_zero, x_neg);
            chk($sformatf("out%0d", AN), {x_cout, x_ovf, x_zero, x_neg, 64'(x_s)}, x_e);
          end
        end
      end
    end

    initial begin
      x_rst = 1'b1; x_in_valid = 1'b0; x_out_ready = 1'b1;
      x_a = '0; x_b = '0; x_cin = 1'b0; x_cnt = 1'b0; x_sat = 1'b0;
      #2 x_rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) x_rst = 1'b1;
      @(posedge clk); #1;

      x_a = AN'(pick(AN)); x_b = AN'(pick(AN)); x_in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      x_in_valid = 1'b0;
      x_lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        x_lat++;
        if (x_out_valid) break;
      end
      chk($sformatf("latency%0d", AN), 68'(x_lat), 68'(ALAT));
      @(posedge clk); #1;

      for (int k = 0; k < 150; k++) begin
        x_in_valid  = ($urandom_range(0, 3) != 0);
        x_out_ready = ($urandom_range(0, 3) != 0);
        x_a   = AN'(pick(AN));
        x_b   = AN'(pick(AN));
        x_cin = 1'($urandom);
        x_cnt = 1'($urandom);
        x_sat = 1'($urandom);
        @(posedge clk); #1;
      end
      x_in_valid  = 1'b0;
      x_out_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
        if (x_sb.size() == 0) break;
        @(posedge clk); #1;
      end
      chk($sformatf("drain%0d", AN), 68'(x_sb.size()), 68'(0));
      x_done = 1'b1;
    end
  end

endmodule
